// File: rtl/lsu_if.sv
// Load/store controller bus bundle: pipeline request, load response, data-memory port, exception.
// slave = controller side, master = pipeline/memory environment side.
interface lsu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wd;
    logic [3:0]        dm_bes;
    logic [6:0]        dm_bel;
    logic [31:0]       dm_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    logic              exc_valid;
    logic [ADDR_W-1:0] exc_addr;
    logic              exc_store;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_tag, dm_rdata, rsp_ready,
        output req_ready, dm_we, dm_addr, dm_wd, dm_bes, dm_bel,
               rsp_valid, rsp_data, rsp_tag, exc_valid, exc_addr, exc_store
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_tag, dm_rdata, rsp_ready,
        input  req_ready, dm_we, dm_addr, dm_wd, dm_bes, dm_bel,
               rsp_valid, rsp_data, rsp_tag, exc_valid, exc_addr, exc_store
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller in front of a registered-read data memory.
// Define LSU_MISALIGN_EXC_EN to trap misaligned word/half accesses instead of ignoring low address bits.
module lsu_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input logic   clk,
    input logic   rst,
    lsu_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_LD_ISSUE, S_LD_CAPT, S_LD_RSP, S_EXC
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic [3:0]        bes_q, bes_d;
    logic [6:0]        bel_q, bel_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       rsp_data_q, rsp_data_d;

    logic       accept, is_store, is_word, is_half, misalign;
    logic [3:0] lane_mask;

    always_comb begin
        is_store = bus.req_op inside {3'b101, 3'b110, 3'b111};
        is_word  = bus.req_op inside {3'b000, 3'b101};
        is_half  = bus.req_op inside {3'b001, 3'b010, 3'b110};
        if (is_word)      lane_mask = 4'b1111;
        else if (is_half) lane_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        else              lane_mask = 4'b0001 << bus.req_addr[1:0];
        accept = bus.req_valid && (state_q == S_IDLE);
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;
    logic              exc_store_q, exc_store_d;

    assign misalign = accept && ((is_word && (bus.req_addr[1:0] != 2'b00)) ||
                                 (is_half && bus.req_addr[0]));

    always_comb begin
        exc_addr_d  = exc_addr_q;
        exc_store_d = exc_store_q;
        if (misalign) begin
            exc_addr_d  = bus.req_addr;
            exc_store_d = bus.req_op[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_addr_q  <= '0;
            exc_store_q <= 1'b0;
        end else begin
            exc_addr_q  <= exc_addr_d;
            exc_store_q <= exc_store_d;
        end
    end

    assign bus.exc_valid = (state_q == S_EXC);
    assign bus.exc_addr  = exc_addr_q;
    assign bus.exc_store = exc_store_q;
`else
    assign misalign      = 1'b0;
    assign bus.exc_valid = 1'b0;
    assign bus.exc_addr  = '0;
    assign bus.exc_store = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wd_q       <= '0;
            bes_q      <= '0;
            bel_q      <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            bes_q      <= bes_d;
            bel_q      <= bel_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        bes_d      = bes_q;
        bel_d      = bel_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        state_d = S_EXC;
                    end else if (is_store) begin
                        state_d = S_ST;
                        addr_d  = bus.req_addr;
                        wd_d    = bus.req_wdata;
                        bes_d   = lane_mask;
                    end else begin
                        state_d = S_LD_ISSUE;
                        addr_d  = bus.req_addr;
                        bel_d   = {bus.req_op, lane_mask};
                        tag_d   = bus.req_tag;
                    end
                end
            end
            S_ST:       state_d = S_IDLE;
            S_LD_ISSUE: state_d = S_LD_CAPT;
            S_LD_CAPT: begin
                rsp_data_d = bus.dm_rdata;
                state_d    = S_LD_RSP;
            end
            S_LD_RSP:   if (bus.rsp_ready) state_d = S_IDLE;
            S_EXC:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // rst gates the write strobe and response so a reset edge never completes a pending access
    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.dm_we     = (state_q == S_ST) && !rst;
        bus.dm_bes    = bus.dm_we ? bes_q : 4'b0000;
        bus.rsp_valid = (state_q == S_LD_RSP) && !rst;
    end

    assign bus.dm_addr  = addr_q;
    assign bus.dm_wd    = wd_q;
    assign bus.dm_bel   = bel_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_tag  = tag_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array data memory model plus a byte-level reference memory.
module tb_lsu_ctrl;

    logic clk;
    logic rst;
    int unsigned n_cmp;
    int unsigned n_err;

    lsu_if #(.ADDR_W(32), .TAG_W(5)) bus ();

    lsu_ctrl #(.ADDR_W(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data memory model (environment) ----------------
    logic [7:0] dmem [0:255] = '{default: 8'h00};

    function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [6:0] bel);
        logic [31:0] v;
        int unsigned k;
        logic [7:0] base;
        v = '0;
        k = 0;
        if ($isunknown({a, bel})) return 32'h0;
        base = {a[7:2], 2'b00};
        for (int l = 0; l < 4; l++) begin
            if (bel[l]) begin
                v |= 32'(dmem[8'(base + 8'(l))]) << (8 * k);
                k++;
            end
        end
        case (bel[6:4])
            3'b001:  if (v[15]) v |= 32'hFFFF0000;
            3'b011:  if (v[7])  v |= 32'hFFFFFF00;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus.dm_we === 1'b1) begin
            for (int l = 0; l < 4; l++) begin
                if (bus.dm_bes[l])
                    dmem[8'({bus.dm_addr[7:2], 2'b00} + 8'(l))] <=
                        8'(bus.dm_wd >> (8 * $countones(bus.dm_bes & 4'((1 << l) - 1))));
            end
        end
        bus.dm_rdata <= dm_read(bus.dm_addr, bus.dm_bel);
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:255] = '{default: 8'h00};

    function automatic int unsigned op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b101:         return 4;
            3'b001, 3'b010, 3'b110: return 2;
            default:                return 1;
        endcase
    endfunction

    function automatic bit is_mis(input logic [2:0] op, input logic [31:0] addr);
`ifdef LSU_MISALIGN_EXC_EN
        return (addr % op_size(op)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        int unsigned sz, e;
        logic [31:0] v;
        sz = op_size(op);
        e  = addr - (addr % sz);
        v  = '0;
        for (int unsigned i = 0; i < sz; i++) v |= 32'(ref_mem[(e + i) % 256]) << (8 * i);
        if (op == 3'b001 && v[15]) v |= 32'hFFFF0000;
        if (op == 3'b011 && v[7])  v |= 32'hFFFFFF00;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        int unsigned sz, e;
        sz = op_size(op);
        e  = addr - (addr % sz);
        for (int unsigned i = 0; i < sz; i++) ref_mem[(e + i) % 256] = 8'(data >> (8 * i));
    endtask

    // ---------------- driver / observer ----------------
    typedef struct {
        logic        acc;
        int unsigned we_cnt;
        logic [3:0]  bes;
        logic [31:0] waddr;
        logic [31:0] wd;
        logic [6:0]  bel;
        int unsigned rsp_edge;
        logic [31:0] rdata;
        logic [4:0]  rtag;
        int unsigned exc_cnt;
        logic [31:0] eaddr;
        logic        estore;
    } obs_t;

    // one request with rsp_ready=1; k counts edges with the accept edge as edge 1
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] tag, output obs_t o);
        o = '{acc: 1'b0, we_cnt: 0, bes: 4'h0, waddr: 32'h0, wd: 32'h0, bel: 7'h0,
              rsp_edge: 0, rdata: 32'h0, rtag: 5'h0, exc_cnt: 0, eaddr: 32'h0, estore: 1'b0};
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_tag   = tag;
        bus.rsp_ready = 1'b1;
        o.acc = bus.req_ready;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) o.bel = bus.dm_bel;
            if (bus.dm_we) begin
                o.we_cnt++;
                o.bes = bus.dm_bes; o.waddr = bus.dm_addr; o.wd = bus.dm_wd;
            end
            if (bus.exc_valid) begin
                o.exc_cnt++;
                o.eaddr = bus.exc_addr; o.estore = bus.exc_store;
            end
            if (bus.rsp_valid && o.rsp_edge == 0) begin
                o.rsp_edge = k; o.rdata = bus.rsp_data; o.rtag = bus.rsp_tag;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        n_cmp++; if (bus.dm_we !== 1'b0) begin n_err++; $display("FAIL reset_dm_we got=%b want=0", bus.dm_we); end
        n_cmp++; if (bus.dm_addr !== 32'h0) begin n_err++; $display("FAIL reset_dm_addr got=%h want=0", bus.dm_addr); end
        n_cmp++; if (bus.dm_wd !== 32'h0) begin n_err++; $display("FAIL reset_dm_wd got=%h want=0", bus.dm_wd); end
        n_cmp++; if (bus.dm_bes !== 4'h0) begin n_err++; $display("FAIL reset_dm_bes got=%b want=0", bus.dm_bes); end
        n_cmp++; if (bus.dm_bel !== 7'h0) begin n_err++; $display("FAIL reset_dm_bel got=%b want=0", bus.dm_bel); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
        n_cmp++; if (bus.rsp_tag !== 5'h0) begin n_err++; $display("FAIL reset_rsp_tag got=%h want=0", bus.rsp_tag); end
        n_cmp++; if ({bus.exc_valid, bus.exc_store, bus.exc_addr} !== 34'h0) begin n_err++; $display("FAIL reset_exc got=%b/%b/%h want=0", bus.exc_valid, bus.exc_store, bus.exc_addr); end
    endtask

    task automatic test_word();
        obs_t o;
        do_req(3'b101, 32'h10, 32'hDEADBEEF, 5'd0, o);
        ref_store(3'b101, 32'h10, 32'hDEADBEEF);
        n_cmp++; if (o.acc !== 1'b1) begin n_err++; $display("FAIL sw_accept got=%b want=1", o.acc); end
        n_cmp++; if (o.we_cnt != 1) begin n_err++; $display("FAIL sw_we_pulses got=%0d want=1", o.we_cnt); end
        n_cmp++; if (o.bes !== 4'b1111) begin n_err++; $display("FAIL sw_bes got=%b want=1111", o.bes); end
        n_cmp++; if (o.waddr !== 32'h10 || o.wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_addr_data got=%h/%h want=10/deadbeef", o.waddr, o.wd); end
        n_cmp++; if (o.rsp_edge != 0) begin n_err++; $display("FAIL sw_no_rsp got=%0d want=0", o.rsp_edge); end
        do_req(3'b000, 32'h10, 32'h0, 5'd7, o);
        n_cmp++; if (o.rsp_edge != 3) begin n_err++; $display("FAIL lw_latency got=%0d want=3", o.rsp_edge); end
        n_cmp++; if (o.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got=%h want=deadbeef", o.rdata); end
        n_cmp++; if (o.rtag !== 5'd7) begin n_err++; $display("FAIL lw_tag got=%0d want=7", o.rtag); end
        n_cmp++; if (o.bel !== 7'b000_1111) begin n_err++; $display("FAIL lw_bel got=%b want=0001111", o.bel); end
        n_cmp++; if (o.we_cnt != 0) begin n_err++; $display("FAIL lw_no_we got=%0d want=0", o.we_cnt); end
    endtask

    task automatic test_byte();
        obs_t o;
        do_req(3'b111, 32'h13, 32'h00000080, 5'd0, o);
        ref_store(3'b111, 32'h13, 32'h00000080);
        n_cmp++; if (o.we_cnt != 1 || o.bes !== 4'b1000) begin n_err++; $display("FAIL sb_bes got=%0d/%b want=1/1000", o.we_cnt, o.bes); end
        do_req(3'b011, 32'h13, 32'h0, 5'd3, o);
        n_cmp++; if (o.bel !== 7'b011_1000) begin n_err++; $display("FAIL lb_bel got=%b want=0111000", o.bel); end
        n_cmp++; if (o.rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data got=%h want=ffffff80", o.rdata); end
        do_req(3'b100, 32'h13, 32'h0, 5'd4, o);
        n_cmp++; if (o.rdata !== 32'h00000080) begin n_err++; $display("FAIL lbu_data got=%h want=00000080", o.rdata); end
        n_cmp++; if (o.rtag !== 5'd4 || o.rsp_edge != 3) begin n_err++; $display("FAIL lbu_tag_lat got=%0d/%0d want=4/3", o.rtag, o.rsp_edge); end
    endtask

    task automatic test_half();
        obs_t o;
        do_req(3'b110, 32'h22, 32'h00008001, 5'd0, o);
        ref_store(3'b110, 32'h22, 32'h00008001);
        n_cmp++; if (o.we_cnt != 1 || o.bes !== 4'b1100) begin n_err++; $display("FAIL sh_bes got=%0d/%b want=1/1100", o.we_cnt, o.bes); end
        do_req(3'b001, 32'h22, 32'h0, 5'd9, o);
        n_cmp++; if (o.rdata !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_data got=%h want=ffff8001", o.rdata); end
        do_req(3'b010, 32'h22, 32'h0, 5'd10, o);
        n_cmp++; if (o.rdata !== 32'h00008001) begin n_err++; $display("FAIL lhu_data got=%h want=00008001", o.rdata); end
        n_cmp++; if (o.bel !== 7'b010_1100) begin n_err++; $display("FAIL lhu_bel got=%b want=0101100", o.bel); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        int unsigned waited;
        exp_d = ref_load(3'b000, 32'h10);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_addr = 32'h10; bus.req_tag = 5'd21;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.rsp_valid && waited < 10);
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_timeout got=%b want=1", bus.rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_tag !== 5'd21 || bus.req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d/%b want=1/%h/21/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.req_ready, exp_d);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b/%b want=0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_req(3'b000, 32'h11, 32'h0, 5'd2, o);
`ifdef LSU_MISALIGN_EXC_EN
        n_cmp++; if (o.exc_cnt != 1 || o.eaddr !== 32'h11 || o.estore !== 1'b0) begin n_err++; $display("FAIL lw_mis_exc got=%0d/%h/%b want=1/11/0", o.exc_cnt, o.eaddr, o.estore); end
        n_cmp++; if (o.we_cnt != 0 || o.rsp_edge != 0) begin n_err++; $display("FAIL lw_mis_quiet got=%0d/%0d want=0/0", o.we_cnt, o.rsp_edge); end
        do_req(3'b110, 32'h21, 32'h00001234, 5'd0, o);
        n_cmp++; if (o.exc_cnt != 1 || o.eaddr !== 32'h21 || o.estore !== 1'b1 || o.we_cnt != 0) begin n_err++; $display("FAIL sh_mis_exc got=%0d/%h/%b/%0d want=1/21/1/0", o.exc_cnt, o.eaddr, o.estore, o.we_cnt); end
`else
        n_cmp++; if (o.rdata !== 32'h80ADBEEF || o.rsp_edge != 3) begin n_err++; $display("FAIL lw_unaligned got=%h/%0d want=80adbeef/3", o.rdata, o.rsp_edge); end
        n_cmp++; if (o.exc_cnt != 0) begin n_err++; $display("FAIL lw_unaligned_exc got=%0d want=0", o.exc_cnt); end
        do_req(3'b110, 32'h21, 32'h00001234, 5'd0, o);
        ref_store(3'b110, 32'h21, 32'h00001234);
        n_cmp++; if (o.we_cnt != 1 || o.bes !== 4'b0011 || o.exc_cnt != 0) begin n_err++; $display("FAIL sh_unaligned got=%0d/%b/%0d want=1/0011/0", o.we_cnt, o.bes, o.exc_cnt); end
`endif
        do_req(3'b010, 32'h20, 32'h0, 5'd1, o);
        n_cmp++; if (o.rdata !== ref_load(3'b010, 32'h20)) begin n_err++; $display("FAIL mis_after_lhu got=%h want=%h", o.rdata, ref_load(3'b010, 32'h20)); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int unsigned seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_addr = 32'h10; bus.req_tag = 5'd5;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.dm_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin n_err++; $display("FAIL rst_ldcapt got=%b/%b/%b/%h want=1/0/0/0", bus.req_ready, bus.dm_we, bus.rsp_valid, bus.rsp_data); end
        seen = 0;
        repeat (5) begin @(negedge clk); if (bus.rsp_valid) seen++; end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_ldcapt_rsp got=%0d want=0", seen); end

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'b101; bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.dm_we !== 1'b0 || bus.dm_bes !== 4'h0) begin n_err++; $display("FAIL rst_st got=%b/%b/%b want=1/0/0000", bus.req_ready, bus.dm_we, bus.dm_bes); end
        do_req(3'b000, 32'h40, 32'h0, 5'd6, o);
        n_cmp++; if (o.rdata !== ref_load(3'b000, 32'h40)) begin n_err++; $display("FAIL rst_st_discard got=%h want=%h", o.rdata, ref_load(3'b000, 32'h40)); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [2:0]  op;
        logic [31:0] addr, data, exp_d;
        logic [4:0]  tag;
        bit          mis;
        for (int n = 0; n < 60; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = 32'h80 + 32'($urandom_range(0, 15));
            data = $urandom;
            tag  = 5'($urandom_range(0, 31));
            mis  = is_mis(op, addr);
            exp_d = ref_load(op, addr);
            do_req(op, addr, data, tag, o);
            n_cmp++; if (o.acc !== 1'b1 || o.exc_cnt != (mis ? 1 : 0)) begin n_err++; $display("FAIL rnd_acc_exc n=%0d got=%b/%0d want=1/%0d", n, o.acc, o.exc_cnt, mis); end
            if (mis) begin
                n_cmp++; if (o.eaddr !== addr || o.estore !== op[2] || o.we_cnt != 0 || o.rsp_edge != 0) begin n_err++; $display("FAIL rnd_exc n=%0d got=%h/%b/%0d/%0d want=%h/%b/0/0", n, o.eaddr, o.estore, o.we_cnt, o.rsp_edge, addr, op[2]); end
            end else if (op >= 3'b101) begin
                ref_store(op, addr, data);
                n_cmp++; if (o.we_cnt != 1 || o.rsp_edge != 0) begin n_err++; $display("FAIL rnd_store n=%0d got=%0d/%0d want=1/0", n, o.we_cnt, o.rsp_edge); end
            end else begin
                n_cmp++; if (o.rdata !== exp_d || o.rtag !== tag || o.rsp_edge != 3 || o.we_cnt != 0) begin n_err++; $display("FAIL rnd_load n=%0d op=%0d a=%h got=%h/%0d/%0d want=%h/%0d/3", n, op, addr, o.rdata, o.rtag, o.rsp_edge, exp_d, tag); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_tag   = 5'h0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_backpressure();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
